// File: rtl/programmable_rate_hex_counter.sv
// programmable_rate_hex_counter
// A rate divider issues an enable tick at one of four selectable periods. Each
// tick steps a DIGITS-nibble up/down counter that wraps at MAX_COUNT. The
// counter also supports a synchronous load and a pause, and every nibble drives
// one active-low seven-segment digit.
module programmable_rate_hex_counter #(
    parameter int          DIGITS    = 2,
    parameter int          DIV_W     = 28,
    parameter int unsigned RATE0     = 0,
    parameter int unsigned RATE1     = 49999999,
    parameter int unsigned RATE2     = 99999999,
    parameter int unsigned RATE3     = 199999999,
    parameter longint unsigned MAX_COUNT = (64'd1 << (4 * DIGITS)) - 64'd1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rate_sel,
    input  logic                  up_down,
    input  logic                  pause,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CW = 4 * DIGITS;

    // Terminal values and the wrap point, narrowed to their register widths.
    localparam logic [DIV_W-1:0] TERM0   = RATE0[DIV_W-1:0];
    localparam logic [DIV_W-1:0] TERM1   = RATE1[DIV_W-1:0];
    localparam logic [DIV_W-1:0] TERM2   = RATE2[DIV_W-1:0];
    localparam logic [DIV_W-1:0] TERM3   = RATE3[DIV_W-1:0];
    localparam logic [CW-1:0]    MAX_C   = MAX_COUNT[CW-1:0];
    localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       rate_q, rate_d;
    logic [CW-1:0]    count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic [DIV_W-1:0] rate_term;
    logic             rate_change;
    logic             fire;

    // Select the terminal value for the currently requested rate.
    always_comb begin
        rate_term = TERM0;
        case (rate_sel)
            2'd0:    rate_term = TERM0;
            2'd1:    rate_term = TERM1;
            2'd2:    rate_term = TERM2;
            default: rate_term = TERM3;
        endcase
    end

    // A changed rate_sel must first be adopted (divider reloaded) before it can
    // fire, so a stale zero in div_cnt never produces a tick at the old rate.
    assign rate_change = (rate_sel != rate_q);
    assign fire        = (div_cnt_q == '0) && !pause && !load && !rate_change;

    // Next state: load beats rate change, rate change beats pause, pause beats fire.
    always_comb begin
        div_cnt_d = div_cnt_q;
        rate_d    = rate_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (load) begin
            // Clamp so the counter never holds a value above the wrap point.
            count_d   = (load_value > MAX_C) ? MAX_C : load_value;
            div_cnt_d = rate_term;
            rate_d    = rate_sel;
        end else if (rate_change) begin
            div_cnt_d = rate_term;
            rate_d    = rate_sel;
        end else if (!pause) begin
            if (fire) begin
                div_cnt_d = rate_term;
                tick_d    = 1'b1;
                if (up_down) begin
                    if (count_q == MAX_C) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end else begin
                // div_cnt_q is non-zero here: a zero with no blocker always fires.
                div_cnt_d = div_cnt_q - DIV_ONE;
            end
        end
    end

    // State register with immediate clear on reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= TERM0;
            rate_q    <= 2'd0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            rate_q    <= rate_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

    // Active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // One decoder per nibble, straight from the registered count.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign hex[7*gi +: 7] = seg7(count_q[4*gi +: 4]);
        end
    endgenerate

endmodule

// File: tb/tb_programmable_rate_hex_counter.sv
// Directed bench for programmable_rate_hex_counter. Three instances share clock
// and reset: A (2 digits, full hex range), B (1 digit, wraps at 9) and
// C (2 digits, wraps at 99). All use rates 0/3/7/15.
`timescale 1ns/1ps
module tb_programmable_rate_hex_counter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A
    logic [1:0]  rate_sel_a;
    logic        up_down_a, pause_a, load_a;
    logic [7:0]  load_value_a, count_a;
    logic        tick_a, wrap_a;
    logic [13:0] hex_a;
    // Instance B
    logic [1:0]  rate_sel_b;
    logic        up_down_b, pause_b, load_b;
    logic [3:0]  load_value_b, count_b;
    logic        tick_b, wrap_b;
    logic [6:0]  hex_b;
    // Instance C
    logic [1:0]  rate_sel_c;
    logic        up_down_c, pause_c, load_c;
    logic [7:0]  load_value_c, count_c;
    logic        tick_c, wrap_c;
    logic [13:0] hex_c;

    programmable_rate_hex_counter #(
        .DIGITS(2), .DIV_W(28), .RATE0(0), .RATE1(3), .RATE2(7), .RATE3(15)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .rate_sel(rate_sel_a), .up_down(up_down_a),
        .pause(pause_a), .load(load_a), .load_value(load_value_a),
        .count(count_a), .tick(tick_a), .wrap(wrap_a), .hex(hex_a)
    );

    programmable_rate_hex_counter #(
        .DIGITS(1), .DIV_W(28), .RATE0(0), .RATE1(3), .RATE2(7), .RATE3(15),
        .MAX_COUNT(9)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .rate_sel(rate_sel_b), .up_down(up_down_b),
        .pause(pause_b), .load(load_b), .load_value(load_value_b),
        .count(count_b), .tick(tick_b), .wrap(wrap_b), .hex(hex_b)
    );

    programmable_rate_hex_counter #(
        .DIGITS(2), .DIV_W(28), .RATE0(0), .RATE1(3), .RATE2(7), .RATE3(15),
        .MAX_COUNT(99)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .rate_sel(rate_sel_c), .up_down(up_down_c),
        .pause(pause_c), .load(load_c), .load_value(load_value_c),
        .count(count_c), .tick(tick_c), .wrap(wrap_c), .hex(hex_c)
    );

    // Advance one clock edge; outputs are then stable and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rate_sel_a = 2'd0; up_down_a = 1'b1; pause_a = 1'b0; load_a = 1'b0; load_value_a = 8'h00;
        rate_sel_b = 2'd0; up_down_b = 1'b1; pause_b = 1'b0; load_b = 1'b0; load_value_b = 4'h0;
        rate_sel_c = 2'd0; up_down_c = 1'b1; pause_c = 1'b0; load_c = 1'b0; load_value_c = 8'h00;
        step();
        step();
        checks++;
        if (count_a !== 8'h00 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%h tick=%b wrap=%b, want 00 0 0", count_a, tick_a, wrap_a);
        end
        checks++;
        if (hex_a !== 14'b1000000_1000000) begin
            errors++;
            $display("FAIL reset_hex: hex=%b, want %b", hex_a, 14'b1000000_1000000);
        end
        $display("reset: count=%h tick=%b wrap=%b hex=%b", count_a, tick_a, wrap_a, hex_a);
        reset_n = 1'b1;
    endtask

    // Rate 0: one step per cycle from the first edge after release.
    task automatic test_rate0();
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (count_a !== 8'(i) || tick_a !== 1'b1 || wrap_a !== 1'b0) begin
                errors++;
                $display("FAIL rate0_step%0d: count=%h tick=%b wrap=%b, want %h 1 0", i, count_a, tick_a, wrap_a, 8'(i));
            end
            if (i == 10) begin
                checks++;
                if (hex_a !== 14'b1000000_0001000) begin
                    errors++;
                    $display("FAIL rate0_hex_0A: hex=%b, want %b", hex_a, 14'b1000000_0001000);
                end
            end
            $display("rate0: cycle=%0d count=%h tick=%b", i, count_a, tick_a);
        end
        // Load near the top, then wrap FF -> 00.
        load_a = 1'b1; load_value_a = 8'hFE;
        step();
        load_a = 1'b0;
        checks++;
        if (count_a !== 8'hFE || tick_a !== 1'b0) begin
            errors++;
            $display("FAIL rate0_load_FE: count=%h tick=%b, want fe 0", count_a, tick_a);
        end
        step();
        checks++;
        if (count_a !== 8'hFF || tick_a !== 1'b1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL rate0_to_FF: count=%h tick=%b wrap=%b, want ff 1 0", count_a, tick_a, wrap_a);
        end
        step();
        checks++;
        if (count_a !== 8'h00 || tick_a !== 1'b1 || wrap_a !== 1'b1) begin
            errors++;
            $display("FAIL rate0_wrap_up: count=%h tick=%b wrap=%b, want 00 1 1", count_a, tick_a, wrap_a);
        end
        step();
        checks++;
        if (count_a !== 8'h01 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL rate0_after_wrap: count=%h wrap=%b, want 01 0", count_a, wrap_a);
        end
        $display("rate0: wrap sequence done count=%h", count_a);
    endtask

    // Modulus-9 single digit (B) and saturating load on modulus 99 (C).
    task automatic test_modulus();
        load_b = 1'b1; load_value_b = 4'h8;
        step();
        load_b = 1'b0;
        checks++;
        if (count_b !== 4'h8 || tick_b !== 1'b0 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL mod9_load8: count=%h tick=%b wrap=%b, want 8 0 0", count_b, tick_b, wrap_b);
        end
        step();
        checks++;
        if (count_b !== 4'h9 || tick_b !== 1'b1 || wrap_b !== 1'b0 || hex_b !== 7'b0010000) begin
            errors++;
            $display("FAIL mod9_to9: count=%h tick=%b wrap=%b hex=%b, want 9 1 0 0010000", count_b, tick_b, wrap_b, hex_b);
        end
        step();
        checks++;
        if (count_b !== 4'h0 || wrap_b !== 1'b1) begin
            errors++;
            $display("FAIL mod9_wrap_up: count=%h wrap=%b, want 0 1", count_b, wrap_b);
        end
        step();
        checks++;
        if (count_b !== 4'h1 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL mod9_after_wrap: count=%h wrap=%b, want 1 0", count_b, wrap_b);
        end
        up_down_b = 1'b0;
        step();
        checks++;
        if (count_b !== 4'h0 || wrap_b !== 1'b0 || tick_b !== 1'b1) begin
            errors++;
            $display("FAIL mod9_down_to0: count=%h wrap=%b tick=%b, want 0 0 1", count_b, wrap_b, tick_b);
        end
        step();
        checks++;
        if (count_b !== 4'h9 || wrap_b !== 1'b1) begin
            errors++;
            $display("FAIL mod9_wrap_down: count=%h wrap=%b, want 9 1", count_b, wrap_b);
        end
        step();
        checks++;
        if (count_b !== 4'h8 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL mod9_down_8: count=%h wrap=%b, want 8 0", count_b, wrap_b);
        end
        load_b = 1'b1; load_value_b = 4'hF;
        step();
        load_b = 1'b0;
        checks++;
        if (count_b !== 4'h9) begin
            errors++;
            $display("FAIL mod9_load_clamp: count=%h, want 9", count_b);
        end
        $display("modulus9: down/wrap/clamp done count=%h", count_b);
        load_c = 1'b1; load_value_c = 8'hFF;
        step();
        load_c = 1'b0;
        checks++;
        if (count_c !== 8'd99 || tick_c !== 1'b0 || hex_c !== 14'b0000010_0110000) begin
            errors++;
            $display("FAIL mod99_load_clamp: count=%0d tick=%b hex=%b, want 99 0 00000100110000", count_c, tick_c, hex_c);
        end
        step();
        checks++;
        if (count_c !== 8'd0 || wrap_c !== 1'b1 || tick_c !== 1'b1) begin
            errors++;
            $display("FAIL mod99_wrap: count=%0d wrap=%b tick=%b, want 0 1 1", count_c, wrap_c, tick_c);
        end
        $display("modulus99: clamp and wrap done count=%0d", count_c);
    endtask

    // Rate 1 from reset: edge 1 adopts the rate (reload 3), edges 2..4 count
    // down 2,1,0, edge 5 fires; after that every 4th edge fires.
    task automatic test_rate1();
        int exp_count;
        logic exp_tick;
        reset_n = 1'b0; rate_sel_a = 2'd1;
        step();
        reset_n = 1'b1;
        exp_count = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_tick = (k == 5 || k == 9 || k == 13 || k == 17);
            if (exp_tick) exp_count++;
            checks++;
            if (count_a !== 8'(exp_count) || tick_a !== exp_tick) begin
                errors++;
                $display("FAIL rate1_edge%0d: count=%h tick=%b, want %h %b", k, count_a, tick_a, 8'(exp_count), exp_tick);
            end
            $display("rate1: edge=%0d count=%h tick=%b", k, count_a, tick_a);
        end
        // 16 cycles after the rate-adoption edge the counter has stepped 4 times.
        checks++;
        if (count_a !== 8'h04) begin
            errors++;
            $display("FAIL rate1_after16: count=%h, want 04", count_a);
        end
    endtask

    // Continues from test_rate1: divider was reloaded to 3 at edge 17.
    task automatic test_load();
        for (int k = 18; k <= 20; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0 || count_a !== 8'h04) begin
                errors++;
                $display("FAIL load_pre_edge%0d: count=%h tick=%b, want 04 0", k, count_a, tick_a);
            end
        end
        // div_cnt is 0 here, load must win over the fire.
        load_a = 1'b1; load_value_a = 8'h3C;
        step();
        load_a = 1'b0;
        checks++;
        if (count_a !== 8'h3C || tick_a !== 1'b0) begin
            errors++;
            $display("FAIL load_3C: count=%h tick=%b, want 3c 0", count_a, tick_a);
        end
        $display("load: count=%h tick=%b", count_a, tick_a);
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0 || count_a !== 8'h3C) begin
                errors++;
                $display("FAIL load_wait%0d: count=%h tick=%b, want 3c 0", k, count_a, tick_a);
            end
        end
        step();
        checks++;
        if (tick_a !== 1'b1 || count_a !== 8'h3D) begin
            errors++;
            $display("FAIL load_next_tick: count=%h tick=%b, want 3d 1", count_a, tick_a);
        end
        $display("load: next tick count=%h", count_a);
    endtask

    // Rate 3 then back to rate 1 mid-period, then pause.
    task automatic test_rate_change_pause();
        rate_sel_a = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0) begin
                errors++;
                $display("FAIL rate3_edge%0d: tick=%b, want 0", k, tick_a);
            end
        end
        rate_sel_a = 2'd1;
        step();
        checks++;
        if (tick_a !== 1'b0 || count_a !== 8'h3D) begin
            errors++;
            $display("FAIL change_cycle: count=%h tick=%b, want 3d 0", count_a, tick_a);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0) begin
                errors++;
                $display("FAIL change_wait%0d: tick=%b, want 0", k, tick_a);
            end
        end
        step();
        checks++;
        if (tick_a !== 1'b1 || count_a !== 8'h3E) begin
            errors++;
            $display("FAIL change_tick: count=%h tick=%b, want 3e 1", count_a, tick_a);
        end
        $display("rate_change: tick 4 cycles after change count=%h", count_a);
        pause_a = 1'b1;
        up_down_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0 || count_a !== 8'h3E) begin
                errors++;
                $display("FAIL pause%0d: count=%h tick=%b, want 3e 0", k, count_a, tick_a);
            end
        end
        pause_a = 1'b0;
        up_down_a = 1'b1;
        // Divider held at 3 through the pause: 3 more edges, then fire.
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (tick_a !== 1'b0) begin
                errors++;
                $display("FAIL unpause_wait%0d: tick=%b, want 0", k, tick_a);
            end
        end
        step();
        checks++;
        if (tick_a !== 1'b1 || count_a !== 8'h3F) begin
            errors++;
            $display("FAIL unpause_tick: count=%h tick=%b, want 3f 1", count_a, tick_a);
        end
        $display("pause: resumed count=%h", count_a);
    endtask

    // reset_n asserted between edges must clear outputs without a clock edge.
    task automatic test_async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count_a !== 8'h00 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%h tick=%b wrap=%b, want 00 0 0", count_a, tick_a, wrap_a);
        end
        $display("async_reset: count=%h tick=%b wrap=%b", count_a, tick_a, wrap_a);
        rate_sel_a = 2'd0;
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (count_a !== 8'h01 || tick_a !== 1'b1) begin
            errors++;
            $display("FAIL async_first_tick: count=%h tick=%b, want 01 1", count_a, tick_a);
        end
        step();
        checks++;
        if (count_a !== 8'h02 || tick_a !== 1'b1) begin
            errors++;
            $display("FAIL async_second_tick: count=%h tick=%b, want 02 1", count_a, tick_a);
        end
        $display("async_reset: restart count=%h", count_a);
    endtask

    initial begin
        test_reset();
        test_rate0();
        test_modulus();
        test_rate1();
        test_load();
        test_rate_change_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
